// File: rtl/pwm_bank_pkg.sv
// ============================================================================
// Module   : pwm_bank_pkg
// Purpose  : Register map, CTRL/STATUS bit positions and address decode for
//            the APB PWM bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_bank_pkg;

    localparam logic [7:0] REG_CTRL      = 8'h00;
    localparam logic [7:0] REG_PERIOD    = 8'h04;
    localparam logic [7:0] REG_PRESCALE  = 8'h08;
    localparam logic [7:0] REG_STATUS    = 8'h0C;
    localparam logic [7:0] REG_DUTY_BASE = 8'h10;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_IRQ_ENA_BIT = 1;
    localparam int STATUS_PEND_BIT  = 0;
    localparam int MAX_CH           = 8;

    typedef enum logic [2:0] {
        SEL_NONE     = 3'd0,
        SEL_CTRL     = 3'd1,
        SEL_PERIOD   = 3'd2,
        SEL_PRESCALE = 3'd3,
        SEL_STATUS   = 3'd4,
        SEL_DUTY     = 3'd5
    } reg_sel_e;

    // Byte lanes are ignored; the duty window grows with the channel count.
    function automatic reg_sel_e decode_sel(input logic [7:0] addr, input int unsigned ch);
        logic [7:0] word_addr;
        word_addr = {addr[7:2], 2'b00};
        if (word_addr == REG_CTRL)     return SEL_CTRL;
        if (word_addr == REG_PERIOD)   return SEL_PERIOD;
        if (word_addr == REG_PRESCALE) return SEL_PRESCALE;
        if (word_addr == REG_STATUS)   return SEL_STATUS;
        if ((word_addr >= REG_DUTY_BASE) && (word_addr < (REG_DUTY_BASE + 8'(ch * 32'd4))))
            return SEL_DUTY;
        return SEL_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_bank_timebase.sv
// ============================================================================
// Module   : pwm_bank_timebase
// Purpose  : Shared prescaler and period counter with period shadow, producing
//            the wrap strobe and the shadow-load strobe for all channels.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_bank_timebase
    import pwm_bank_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int PSC_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 en_rise_i,
    input  logic [PSC_WIDTH-1:0] prescale_i,
    input  logic [WIDTH-1:0]     period_i,
    output logic [WIDTH-1:0]     cnt_o,
    output logic                 wrap_o,
    output logic                 load_o
);

    logic [PSC_WIDTH-1:0] psc_q, psc_d;
    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     period_sh_q, period_sh_d;
    logic                 w_tick;
    logic                 w_wrap;

    always_comb begin
        psc_d       = psc_q;
        cnt_d       = cnt_q;
        period_sh_d = period_sh_q;
        w_tick      = 1'b0;
        w_wrap      = 1'b0;
        if (en_rise_i) begin
            psc_d       = '0;
            cnt_d       = '0;
            period_sh_d = period_i;
        end else if (!en_i) begin
            psc_d = '0;
            cnt_d = '0;
        end else begin
            // >= keeps a mid-run PRESCALE reduction from running psc past it
            w_tick = (psc_q >= prescale_i);
            if (w_tick) begin
                psc_d = '0;
                if (cnt_q == period_sh_q) begin
                    w_wrap      = 1'b1;
                    cnt_d       = '0;
                    period_sh_d = period_i;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                psc_d = psc_q + PSC_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            psc_q       <= '0;
            cnt_q       <= '0;
            period_sh_q <= '0;
        end else begin
            psc_q       <= psc_d;
            cnt_q       <= cnt_d;
            period_sh_q <= period_sh_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = w_wrap;
    assign load_o = w_wrap | en_rise_i;

endmodule

`default_nettype wire

// File: rtl/apb_pwm_bank.sv
// ============================================================================
// Module   : apb_pwm_bank
// Purpose  : CH-channel PWM generator with double-buffered duty registers on
//            an APB3 slave. Define PWM_BANK_IRQ_EN for the period-end IRQ.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int CH        = 2,
    parameter int WIDTH     = 16,
    parameter int PSC_WIDTH = 8
) (
    input  logic          SYSCLK,
    input  logic          SYSRESET,
    input  logic          PSEL,
    input  logic          PENABLE,
    input  logic          PWRITE,
    input  logic [7:0]    PADDR,
    input  logic [31:0]   PWDATA,
    output logic [31:0]   PRDATA,
    output logic          PREADY,
    output logic          PSLVERR,
    output logic [CH-1:0] PWM,
    output logic          IRQ
);

    reg_sel_e                     w_sel;
    logic                         w_access;
    logic                         w_mapped;
    logic                         w_wr;
    logic [5:0]                   w_duty_idx;
    logic                         w_en_rise;
    logic                         w_irq_ena;
    logic [WIDTH-1:0]             w_cnt;
    logic                         w_wrap;
    logic                         w_load;
    logic [CH-1:0][WIDTH-1:0]     w_duty_rd;
    logic                         w_unused;

    logic                         en_q, en_d;
    logic [WIDTH-1:0]             period_q, period_d;
    logic [PSC_WIDTH-1:0]         prescale_q, prescale_d;
    logic                         pend_q, pend_d;

    assign w_sel      = decode_sel(PADDR, CH);
    assign w_access   = PSEL & PENABLE;
    assign w_mapped   = (w_sel != SEL_NONE);
    assign w_wr       = w_access & PWRITE & w_mapped;
    assign w_duty_idx = PADDR[7:2] - 6'(REG_DUTY_BASE >> 2);
    assign w_unused   = ^{PADDR[1:0], PWDATA};

    assign PREADY  = 1'b1;
    assign PSLVERR = w_access & ~w_mapped;

    always_comb begin
        en_d       = en_q;
        period_d   = period_q;
        prescale_d = prescale_q;
        pend_d     = pend_q;
        if (w_wr) begin
            case (w_sel)
                SEL_CTRL:     en_d       = PWDATA[CTRL_EN_BIT];
                SEL_PERIOD:   period_d   = PWDATA[WIDTH-1:0];
                SEL_PRESCALE: prescale_d = PWDATA[PSC_WIDTH-1:0];
                SEL_STATUS:   if (PWDATA[STATUS_PEND_BIT]) pend_d = 1'b0;
                default:      ;
            endcase
        end
        // A wrap in the same cycle as the W1C must leave PEND set.
        if (w_wrap) pend_d = 1'b1;
    end

    assign w_en_rise = ~en_q & en_d;

    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            en_q       <= 1'b0;
            period_q   <= '0;
            prescale_q <= '0;
            pend_q     <= 1'b0;
        end else begin
            en_q       <= en_d;
            period_q   <= period_d;
            prescale_q <= prescale_d;
            pend_q     <= pend_d;
        end
    end

`ifdef PWM_BANK_IRQ_EN
    logic irq_ena_q, irq_ena_d;
    logic irq_q, irq_d;

    always_comb begin
        irq_ena_d = irq_ena_q;
        if (w_wr && (w_sel == SEL_CTRL)) irq_ena_d = PWDATA[CTRL_IRQ_ENA_BIT];
        irq_d = pend_q & irq_ena_q;
    end

    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            irq_ena_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            irq_ena_q <= irq_ena_d;
            irq_q     <= irq_d;
        end
    end

    assign w_irq_ena = irq_ena_q;
    assign IRQ       = irq_q;
`else
    assign w_irq_ena = 1'b0;
    assign IRQ       = 1'b0;
`endif

    pwm_bank_timebase #(
        .WIDTH     (WIDTH),
        .PSC_WIDTH (PSC_WIDTH)
    ) u_timebase (
        .clk_i      (SYSCLK),
        .rst_i      (SYSRESET),
        .en_i       (en_q),
        .en_rise_i  (w_en_rise),
        .prescale_i (prescale_q),
        .period_i   (period_q),
        .cnt_o      (w_cnt),
        .wrap_o     (w_wrap),
        .load_o     (w_load)
    );

    // Live duty is captured into the shadow only on wrap or enable rise.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic             w_duty_wr;
        logic [WIDTH-1:0] duty_q, duty_d;
        logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
        logic             pwm_q, pwm_d;

        assign w_duty_wr = w_wr && (w_sel == SEL_DUTY) && (w_duty_idx == 6'(i));
        assign duty_d    = w_duty_wr ? PWDATA[WIDTH-1:0] : duty_q;
        assign duty_sh_d = w_load ? duty_q : duty_sh_q;
        assign pwm_d     = en_q & (w_cnt < duty_sh_q);

        always_ff @(posedge SYSCLK or posedge SYSRESET) begin
            if (SYSRESET) begin
                duty_q    <= '0;
                duty_sh_q <= '0;
                pwm_q     <= 1'b0;
            end else begin
                duty_q    <= duty_d;
                duty_sh_q <= duty_sh_d;
                pwm_q     <= pwm_d;
            end
        end

        assign w_duty_rd[i] = duty_q;
        assign PWM[i]       = pwm_q;
    end

    always_comb begin
        PRDATA = '0;
        case (w_sel)
            SEL_CTRL: begin
                PRDATA[CTRL_EN_BIT]      = en_q;
                PRDATA[CTRL_IRQ_ENA_BIT] = w_irq_ena;
            end
            SEL_PERIOD:   PRDATA[WIDTH-1:0]       = period_q;
            SEL_PRESCALE: PRDATA[PSC_WIDTH-1:0]   = prescale_q;
            SEL_STATUS:   PRDATA[STATUS_PEND_BIT] = pend_q;
            SEL_DUTY: begin
                for (int i = 0; i < CH; i++) begin
                    if (w_duty_idx == 6'(i)) PRDATA[WIDTH-1:0] = w_duty_rd[i];
                end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_apb_pwm_bank.sv
// ============================================================================
// Module   : tb_apb_pwm_bank
// Purpose  : Directed self-checking bench for apb_pwm_bank (CH=2, WIDTH=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_pwm_bank;

`ifdef PWM_BANK_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [1:0]  pwm;
    logic        irq;

    logic [31:0] last_rd;
    logic        last_err;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    apb_pwm_bank #(
        .CH        (2),
        .WIDTH     (16),
        .PSC_WIDTH (8)
    ) dut (
        .SYSCLK   (clk),
        .SYSRESET (rst),
        .PSEL     (psel),
        .PENABLE  (penable),
        .PWRITE   (pwrite),
        .PADDR    (paddr),
        .PWDATA   (pwdata),
        .PRDATA   (prdata),
        .PREADY   (pready),
        .PSLVERR  (pslverr),
        .PWM      (pwm),
        .IRQ      (irq)
    );

    // Returns on the negedge right after the commit edge.
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        #1 last_err = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk);
        penable = 1'b1;
        #1 begin last_rd = prdata; last_err = pslverr; end
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (pwm !== 2'b00 || irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got pwm=%b irq=%b, expected pwm=00 irq=0", pwm, irq);
        end
        rst = 1'b0;
        n_checks++;
        if (pready !== 1'b1) begin
            n_fail++; $display("FAIL pready: got %b expected 1", pready);
        end
        for (int i = 0; i < 6; i++) begin
            apb_read(8'(i * 4));
            n_checks++;
            if (last_rd !== 32'h0) begin
                n_fail++; $display("FAIL reset_read_%0h: got %h expected 0", i * 4, last_rd);
            end
            n_checks++;
            if (last_err !== 1'b0) begin
                n_fail++; $display("FAIL reset_pslverr_%0h: got %b expected 0", i * 4, last_err);
            end
        end
    endtask

    task automatic test_basic();
        logic [27:0] got0, got1, exp0, exp1;
        apb_write(8'h04, 32'd9);
        apb_write(8'h08, 32'd0);
        apb_write(8'h10, 32'd3);
        apb_write(8'h14, 32'd10);
        apb_write(8'h00, 32'd1);
        for (int k = 0; k < 28; k++) begin
            got0[k] = pwm[0];
            got1[k] = pwm[1];
            exp0[k] = (k >= 1) && (((k - 1) % 10) < 3);
            exp1[k] = (k >= 1);
            @(negedge clk);
        end
        n_checks++;
        if (got0 !== exp0) begin
            n_fail++; $display("FAIL basic_pwm0: got %b expected %b", got0, exp0);
        end
        n_checks++;
        if (got1 !== exp1) begin
            n_fail++; $display("FAIL basic_pwm1_const_high: got %b expected %b", got1, exp1);
        end
    endtask

    // Continues the running period: the DUTY0 write commits while PWM0 is high.
    task automatic test_duty_update();
        logic [19:0] got, exp;
        apb_write(8'h10, 32'd7);
        for (int j = 0; j < 20; j++) begin
            got[j] = pwm[0];
            exp[j] = (j < 3) || (j >= 10 && j < 17);
            @(negedge clk);
        end
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL duty_update: got %b expected %b", got, exp);
        end
        apb_read(8'h0C);
        n_checks++;
        if (last_rd !== 32'h1) begin
            n_fail++; $display("FAIL pend_after_wraps: got %h expected 1", last_rd);
        end
    endtask

    task automatic test_prescale();
        logic [39:0] got, exp;
        apb_write(8'h00, 32'd0);
        apb_write(8'h08, 32'd4);
        apb_write(8'h04, 32'd3);
        apb_write(8'h10, 32'd2);
        apb_write(8'h00, 32'd1);
        for (int k = 0; k < 40; k++) begin
            got[k] = pwm[0];
            exp[k] = (k >= 1) && ((((k - 1) / 5) % 4) < 2);
            @(negedge clk);
        end
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL prescale_pwm0: got %b expected %b", got, exp);
        end
        apb_write(8'h00, 32'd0);
        n_checks++;
        if (pwm[0] !== 1'b1) begin
            n_fail++; $display("FAIL en_clear_pre: got %b expected 1", pwm[0]);
        end
        @(negedge clk);
        n_checks++;
        if (pwm !== 2'b00) begin
            n_fail++; $display("FAIL en_clear_drop: got %b expected 00", pwm);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (pwm !== 2'b00) begin
            n_fail++; $display("FAIL en_clear_hold: got %b expected 00", pwm);
        end
    endtask

    task automatic test_irq();
        logic [16:0] got, exp;
        apb_write(8'h08, 32'd0);
        apb_write(8'h04, 32'd9);
        apb_write(8'h0C, 32'd1);
        apb_read(8'h0C);
        n_checks++;
        if (last_rd !== 32'h0) begin
            n_fail++; $display("FAIL pend_w1c_idle: got %h expected 0", last_rd);
        end
        apb_write(8'h00, 32'd3);
        for (int k = 0; k < 17; k++) begin
            got[k] = irq;
            exp[k] = IRQ_BUILD && (k >= 11);
            @(negedge clk);
        end
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL irq_rise: got %b expected %b", got, exp);
        end
        // Clear commits on the same edge as the second wrap.
        apb_write(8'h0C, 32'd1);
        @(negedge clk);
        n_checks++;
        if (irq !== IRQ_BUILD) begin
            n_fail++; $display("FAIL irq_clear_vs_wrap: got %b expected %b", irq, IRQ_BUILD);
        end
        apb_read(8'h0C);
        n_checks++;
        if (last_rd !== 32'h1) begin
            n_fail++; $display("FAIL pend_set_wins: got %h expected 1", last_rd);
        end
        apb_write(8'h0C, 32'd1);
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_cleared: got %b expected 0", irq);
        end
        apb_read(8'h00);
        n_checks++;
        if (last_rd !== (IRQ_BUILD ? 32'h3 : 32'h1)) begin
            n_fail++; $display("FAIL ctrl_readback: got %h expected %h", last_rd, IRQ_BUILD ? 32'h3 : 32'h1);
        end
        apb_write(8'h00, 32'd0);
    endtask

    task automatic test_unmapped();
        logic [7:0]  addrs [2];
        logic [7:0]  raddr [4];
        logic [31:0] rexp  [4];
        addrs = '{8'h40, 8'h18};
        foreach (addrs[i]) begin
            apb_read(addrs[i]);
            n_checks++;
            if (last_rd !== 32'h0 || last_err !== 1'b1) begin
                n_fail++; $display("FAIL unmapped_read_%h: got data=%h err=%b expected data=0 err=1", addrs[i], last_rd, last_err);
            end
            apb_write(addrs[i], 32'hFFFF_FFFF);
            n_checks++;
            if (last_err !== 1'b1) begin
                n_fail++; $display("FAIL unmapped_write_%h: got err=%b expected 1", addrs[i], last_err);
            end
        end
        apb_write(8'h04, 32'hFFFF_0009);
        raddr = '{8'h00, 8'h04, 8'h10, 8'h14};
        rexp  = '{32'h0, 32'h9, 32'h2, 32'hA};
        foreach (raddr[i]) begin
            apb_read(raddr[i]);
            n_checks++;
            if (last_rd !== rexp[i] || last_err !== 1'b0) begin
                n_fail++; $display("FAIL state_kept_%h: got data=%h err=%b expected data=%h err=0", raddr[i], last_rd, last_err, rexp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        apb_write(8'h10, 32'd3);
        apb_write(8'h00, 32'd1);
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (pwm[0] === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL reset_mid_wait: got no PWM0 high within 40 cycles, expected high");
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (pwm !== 2'b00 || irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_async: got pwm=%b irq=%b expected 00/0", pwm, irq);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apb_read(8'(i * 4));
            n_checks++;
            if (last_rd !== 32'h0) begin
                n_fail++; $display("FAIL reset_mid_read_%0h: got %h expected 0", i * 4, last_rd);
            end
        end
        n_checks++;
        if (pwm !== 2'b00) begin
            n_fail++; $display("FAIL reset_mid_pwm: got %b expected 00", pwm);
        end
    endtask

    // PERIOD=0 gives a one-tick period: DUTY0=1 constant high, DUTY1=0 constant low.
    task automatic test_boundary();
        logic [19:0] got, exp;
        apb_write(8'h10, 32'd1);
        apb_write(8'h00, 32'd1);
        @(negedge clk);
        for (int j = 0; j < 10; j++) begin
            got[2*j +: 2] = pwm;
            exp[2*j +: 2] = 2'b01;
            @(negedge clk);
        end
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL period_zero: got %b expected %b", got, exp);
        end
        apb_read(8'h0C);
        n_checks++;
        if (last_rd !== 32'h1) begin
            n_fail++; $display("FAIL period_zero_pend: got %h expected 1", last_rd);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duty_update();
        test_prescale();
        test_irq();
        test_unmapped();
        test_reset_mid();
        test_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
